// File: rtl/instr_sequencer.sv
// Program sequencer: owns the PC, fetches instruction words over req/ack,
// steps the control unit through EXEC and retires instructions on done.
module instr_sequencer #(
  parameter int PC_W     = 5,
  parameter int PROG_LEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [8:0]      mem_data,
  output logic [8:0]      ir,
  output logic [1:0]      state,
  output logic            run,
  input  logic            done,
  output logic            busy,
  output logic [15:0]     instr_count,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fsm_t;

  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(PROG_LEN - 1);

  fsm_t            fsm;
  fsm_t            fsm_next;
  logic [PC_W-1:0] pc;
  logic [1:0]      step;
  logic            stop_pend;

  logic            launch;
  logic            load_ir;
  logic            retire;
  logic            overrun;
  logic            halt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    fsm_next = fsm;
    launch   = 1'b0;
    load_ir  = 1'b0;
    retire   = 1'b0;
    overrun  = 1'b0;
    halt     = 1'b0;
    unique case (fsm)
      IDLE: begin
        if (start) begin
          launch   = 1'b1;
          fsm_next = FETCH;
        end
      end
      FETCH: begin
        if (mem_ack) begin
          load_ir  = 1'b1;
          fsm_next = EXEC;
        end
      end
      EXEC: begin
        // Step 3 ending without done is an overrun, retired like a normal done.
        overrun = !done && (step == 2'd3);
        retire  = done || overrun;
        halt    = retire && (stop_pend || stop);
        if (retire) begin
          fsm_next = halt ? IDLE : FETCH;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      step        <= 2'd0;
      stop_pend   <= 1'b0;
      ir          <= 9'h000;
      instr_count <= 16'd0;
      err         <= 1'b0;
    end else begin
      if (launch) begin
        pc          <= '0;
        instr_count <= 16'd0;
        err         <= 1'b0;
        stop_pend   <= 1'b0;
      end

      if (load_ir) begin
        ir   <= mem_data;
        step <= 2'd0;
      end else if (fsm == EXEC && !retire) begin
        step <= step + 2'd1;
      end

      if (retire) begin
        pc <= (pc == LAST_ADDR) ? '0 : pc + PC_W'(1);
        if (instr_count != 16'hFFFF) begin
          instr_count <= instr_count + 16'd1;
        end
        if (overrun) begin
          err <= 1'b1;
        end
      end

      // A halting retire consumes the request; stop in IDLE never latches.
      if (halt) begin
        stop_pend <= 1'b0;
      end else if (fsm != IDLE && stop) begin
        stop_pend <= 1'b1;
      end
    end
  end

  assign mem_req  = (fsm == FETCH);
  assign mem_addr = pc;
  assign run      = (fsm == EXEC);
  assign busy     = (fsm != IDLE);
  assign state    = (fsm == EXEC) ? step : 2'd0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: memory and control-unit responders,
// a program-level reference model feeding a scoreboard, and a retire monitor.
module tb_instr_sequencer;

  localparam int PC_W     = 3;
  localparam int PROG_LEN = 6;

  logic            clk;
  logic            reset;
  logic            start;
  logic            stop;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [8:0]      mem_data;
  logic [8:0]      ir;
  logic [1:0]      state;
  logic            run;
  logic            done;
  logic            busy;
  logic [15:0]     instr_count;
  logic            err;

  instr_sequencer #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .ir          (ir),
    .state       (state),
    .run         (run),
    .done        (done),
    .busy        (busy),
    .instr_count (instr_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         addr;
    logic [8:0] word;
    int         cycles;
    logic       err;
    int         count;
    logic       last;
  } rec_t;

  rec_t       exp_q[$];
  logic [8:0] prog [8];
  int         n_chk = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode field [8:7] selects the step where the control unit raises done;
  // 4 means it never does, forcing an overrun.
  function automatic int done_step(input logic [8:0] w);
    case (w[8:7])
      2'b00:   return 1;
      2'b01:   return 3;
      2'b10:   return 0;
      default: return 4;
    endcase
  endfunction

  // Reference model: the run of n instructions from address 0.
  task automatic plan_run(input int n);
    int   a = 0;
    logic e = 1'b0;
    for (int i = 0; i < n; i++) begin
      rec_t r;
      int   ds = done_step(prog[a]);
      e        = e | (ds > 3);
      r.addr   = a;
      r.word   = prog[a];
      r.cycles = (ds > 3) ? 4 : ds + 1;
      r.err    = e;
      r.count  = i + 1;
      r.last   = (i == n - 1);
      exp_q.push_back(r);
      a = (a + 1) % PROG_LEN;
    end
  endtask

  // Memory and control-unit responders, driven right at the falling edge.
  initial begin
    int wait_left = 0;
    bit in_fetch  = 0;
    mem_ack  = 1'b0;
    mem_data = 9'h000;
    done     = 1'b0;
    forever begin
      @(negedge clk);
      done = run ? (int'(state) == done_step(ir)) : 1'($urandom_range(0, 1));
      if (mem_req && !reset) begin
        if (!in_fetch) begin
          in_fetch  = 1;
          wait_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
        end
        if (wait_left == 0) begin
          mem_ack  = 1'b1;
          mem_data = prog[mem_addr];
          in_fetch = 0;
        end else begin
          mem_ack = 1'b0;
          wait_left--;
        end
      end else begin
        in_fetch = 0;
        mem_ack  = 1'b0;
      end
      if (!mem_ack) mem_data = 9'($urandom);
    end
  end

  // Monitor: samples 1 time unit after the falling edge, pops on each retire.
  initial begin
    rec_t       last_r;
    logic [8:0] exp_ir = 9'h000;
    int         exec_cyc = 0;
    bit         post_retire = 0;
    bit         post_ack = 0;
    logic       prev_busy = 1'b0;
    last_r = '{addr: 0, word: 9'h000, cycles: 0, err: 1'b0, count: 0, last: 1'b0};
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        exp_ir      = 9'h000;
        exec_cyc    = 0;
        post_retire = 0;
        post_ack    = 0;
        prev_busy   = 1'b0;
        continue;
      end
      if (busy && !prev_busy) begin
        check("start_req", {31'd0, mem_req}, 32'd1);
        check("start_addr", 32'(mem_addr), 32'd0);
        check("start_count", 32'(instr_count), 32'd0);
        check("start_err", {31'd0, err}, 32'd0);
      end
      if (post_retire) begin
        post_retire = 0;
        check("ret_count", 32'(instr_count), 32'(last_r.count));
        check("ret_err", {31'd0, err}, {31'd0, last_r.err});
        check("ret_busy", {31'd0, busy}, {31'd0, !last_r.last});
        check("ret_req", {31'd0, mem_req}, {31'd0, !last_r.last});
        check("ret_next_addr", 32'(mem_addr), 32'((last_r.addr + 1) % PROG_LEN));
      end
      if (post_ack) begin
        post_ack = 0;
        check("ack_to_exec", {30'd0, run, state == 2'd0}, 32'd3);
      end
      if (mem_req) begin
        check("fetch_hold", {22'd0, run, state, ir}, {23'd0, 2'd0, exp_ir});
        if (mem_ack) post_ack = 1;
        exec_cyc = 0;
      end
      if (run) begin
        check("step", 32'(state), 32'(exec_cyc));
        exec_cyc++;
        if (done || state == 2'd3) begin
          if (exp_q.size() == 0) begin
            check("unexpected_retire", 32'd1, 32'd0);
          end else begin
            last_r = exp_q.pop_front();
            check("retire_addr", 32'(mem_addr), 32'(last_r.addr));
            check("retire_ir", 32'(ir), 32'(last_r.word));
            check("retire_cycles", 32'(exec_cyc), 32'(last_r.cycles));
            exp_ir      = last_r.word;
            post_retire = 1;
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic new_program();
    for (int i = 0; i < 8; i++) prog[i] = 9'($urandom);
  endtask

  // One run of n instructions; stop lands in instruction n-1's fetch or step 0.
  task automatic do_run(input int n);
    int acks = 0;
    int mode = int'($urandom_range(0, 1));
    bit stop_sent = 0;
    bit finished = 0;
    plan_run(n);
    if ($urandom_range(0, 2) == 0) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    tick();
    start = 1'b1;
    stop  = 1'($urandom_range(0, 3) == 0);
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (!stop_sent) begin
        if ((mode == 0 && mem_req && acks == n - 1) ||
            (mode == 1 && run && state == 2'd0 && acks == n)) begin
          stop      = 1'b1;
          stop_sent = 1;
        end
      end
      if (mem_req && mem_ack) acks++;
      if (busy && $urandom_range(0, 15) == 0) start = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      if (stop_sent && !busy) finished = 1;
    end
    check("halt_reached", {31'd0, finished}, 32'd1);
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit found = 0;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    new_program();
    tick();
    tick();
    check("rst_outputs", {22'd0, mem_req, run, busy, err, state, 2'(mem_addr), 2'd0},
          32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    for (int r = 0; r < 8; r++) begin
      new_program();
      do_run(int'($urandom_range(1, 12)));
    end

    // Asynchronous reset in the middle of step 2.
    new_program();
    prog[0][8:7] = 2'b01;
    plan_run(50);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (run && state == 2'd2) found = 1;
      else tick();
    end
    check("reach_step2", {31'd0, found}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_exec", {27'd0, run, busy, mem_req, state}, 32'd0);
    check("rst_mid_count", 32'(instr_count), 32'd0);
    check("rst_mid_err_addr", {28'd0, err, mem_addr}, 32'd0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("stay_idle", {30'd0, busy, mem_req}, 32'd0);

    new_program();
    do_run(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
